// File: rtl/codebreak_pkg.sv
// Shared types and defaults for the RC4 key-search scheduler and its helpers.
package codebreak_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    FOUND,
    EXHAUSTED
  } sched_state_t;

  localparam int          KEY_W_DEF    = 24;
  localparam logic [23:0] KEY_LAST_DEF = 24'h3FFFFF;

  // Core count is capped at 16, so a 16-bit popcount covers every build.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/key_slot_pick.sv
// Lowest-index-set priority encoder: valid plus index of the first request bit.
module key_slot_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/key_search_sched.sv
// Shares an ascending RC4 key range across NUM_CORES decrypt cores and records the first hit.
// Optional keys_done progress counter is built when KEY_PROGRESS_EN is defined.
module key_search_sched
  import codebreak_pkg::*;
#(
  parameter int               NUM_CORES = 4,
  parameter int               KEY_W     = KEY_W_DEF,
  parameter logic [KEY_W-1:0] KEY_FIRST = '0,
  parameter logic [KEY_W-1:0] KEY_LAST  = KEY_LAST_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_cracked,
  output logic                       busy,
  output logic                       cracked,
  output logic                       failed,
  output logic [KEY_W-1:0]           found_key,
  output sched_state_t               dbg_state
`ifdef KEY_PROGRESS_EN
  ,
  output logic [KEY_W:0]             keys_done
`endif
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // Core handshake: core_start[i] is a one-cycle request carrying core_key[i];
  // the core answers later with a one-cycle core_done[i] (core_cracked[i] qualifies it).
  // Between the two the core counts as busy and its key is frozen.
  sched_state_t             state, state_nxt;
  logic [KEY_W:0]           next_key, next_key_nxt, issue_key;
  logic [NUM_CORES-1:0]     core_busy, busy_nxt, start_nxt;
  logic [NUM_CORES-1:0]     done_v, crack_req, free_req;
  logic [KEY_W-1:0]         core_key_q [NUM_CORES];
  logic [KEY_W-1:0]         found_nxt, found_key_q;
  logic                     hit, hit_nxt, issued_all, issued_nxt;
  logic                     active, go_ok, capture, dispatch_en;
  logic                     free_v, win_v;
  logic [IDX_W-1:0]         free_idx, win_idx;

  assign active    = (state == DISPATCH) || (state == DRAIN);
  assign go_ok     = go && ((state == IDLE) || (state == FOUND) || (state == EXHAUSTED));
  assign done_v    = active ? (core_done & core_busy) : '0;
  assign crack_req = done_v & core_cracked;
  assign free_req  = ~core_busy & ~core_done;
  assign capture   = active && win_v && !hit;
  assign issue_key = go_ok ? {1'b0, KEY_FIRST} : next_key;
  // The accepted go dispatches its first key on the same edge so the start follows go directly.
  assign dispatch_en = go_ok || ((state == DISPATCH) && !capture && !issued_all &&
                                 (next_key <= {1'b0, KEY_LAST}));

  key_slot_pick #(.N(NUM_CORES), .IDX_W(IDX_W)) u_free_pick (
    .req   (free_req),
    .valid (free_v),
    .idx   (free_idx)
  );

  key_slot_pick #(.N(NUM_CORES), .IDX_W(IDX_W)) u_win_pick (
    .req   (crack_req),
    .valid (win_v),
    .idx   (win_idx)
  );

  always_comb begin
    state_nxt    = state;
    next_key_nxt = next_key;
    busy_nxt     = core_busy & ~done_v;
    start_nxt    = '0;
    hit_nxt      = hit;
    found_nxt    = found_key_q;
    issued_nxt   = issued_all;
    if (capture) begin
      hit_nxt = 1'b1;
      for (int i = 0; i < NUM_CORES; i++)
        if (win_idx == IDX_W'(i)) found_nxt = core_key_q[i];
    end
    if (go_ok) begin
      state_nxt    = DISPATCH;
      hit_nxt      = 1'b0;
      found_nxt    = '0;
      issued_nxt   = 1'b0;
      next_key_nxt = {1'b0, KEY_FIRST};
    end
    if ((state == DISPATCH) && capture) state_nxt = DRAIN;
    if ((state == DRAIN) && (busy_nxt == '0)) state_nxt = hit_nxt ? FOUND : EXHAUSTED;
    if (dispatch_en && free_v) begin
      for (int i = 0; i < NUM_CORES; i++)
        if (free_idx == IDX_W'(i)) start_nxt[i] = 1'b1;
      busy_nxt     = busy_nxt | start_nxt;
      next_key_nxt = issue_key + (KEY_W + 1)'(1);
      if (issue_key == {1'b0, KEY_LAST}) begin
        issued_nxt = 1'b1;
        state_nxt  = DRAIN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      next_key    <= {1'b0, KEY_FIRST};
      core_busy   <= '0;
      core_start  <= '0;
      hit         <= 1'b0;
      issued_all  <= 1'b0;
      found_key_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) core_key_q[i] <= '0;
    end else begin
      state       <= state_nxt;
      next_key    <= next_key_nxt;
      core_busy   <= busy_nxt;
      core_start  <= start_nxt;
      hit         <= hit_nxt;
      issued_all  <= issued_nxt;
      found_key_q <= found_nxt;
      for (int i = 0; i < NUM_CORES; i++)
        if (start_nxt[i]) core_key_q[i] <= issue_key[KEY_W-1:0];
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key
    assign core_key[g*KEY_W +: KEY_W] = core_key_q[g];
  end

  assign busy      = active;
  assign cracked   = (state == FOUND);
  assign failed    = (state == EXHAUSTED);
  assign found_key = found_key_q;
  assign dbg_state = state;

`ifdef KEY_PROGRESS_EN
  localparam logic [KEY_W+1:0] PROG_MAX = (KEY_W + 2)'(1) << KEY_W;
  logic [KEY_W+1:0] prog_sum;

  assign prog_sum = {1'b0, keys_done} + (KEY_W + 2)'(popcount16(16'(core_done)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    keys_done <= '0;
    else if (go_ok)             keys_done <= '0;
    else if (prog_sum > PROG_MAX) keys_done <= PROG_MAX[KEY_W:0];
    else                        keys_done <= prog_sum[KEY_W:0];
  end
`endif

`ifndef SYNTHESIS
  // A done from an idle core means the core array and this block disagree about ownership.
  assert property (@(posedge clk) disable iff (rst) (core_done & ~core_busy) == '0);
`endif

endmodule

// File: doc/key_search_sched.md
Name: key_search_sched

Overview:
- Scheduler that shares a 24-bit RC4 key space across NUM_CORES identical decrypt cores; each core is an RC4 decrypt FSM with its own S RAM, message ROM and decrypted-message RAM.
- Hands out candidate keys in ascending order, one dispatch per cycle, and tracks which cores are busy.
- Records the first key that a core reports as cracked, then drains the in-flight cores.
- Sits between the switch/key-control logic and the core array; drives the DE1-SoC LEDs.

Parameters:
- NUM_CORES, 4, number of decrypt cores, 1..16.
- KEY_W, 24, secret key width.
- KEY_FIRST, 24'h000000, first key issued.
- KEY_LAST, 24'h3FFFFF, last key issued; range is inclusive.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- go  in  1  one-cycle pulse; starts a search; honoured only in IDLE, FOUND or EXHAUSTED.
- core_start  out  NUM_CORES  one-cycle start pulse per core.
- core_key  out  NUM_CORES*KEY_W  key for core i at bits [i*KEY_W +: KEY_W]; held stable from start until done.
- core_done  in  NUM_CORES  one-cycle pulse per core when its decrypt finishes.
- core_cracked  in  NUM_CORES  valid only with core_done; 1 means the plaintext passed the check.
- busy  out  1  high in DISPATCH and DRAIN.
- cracked  out  1  LED0; high in FOUND.
- failed  out  1  LED1; high in EXHAUSTED.
- found_key  out  KEY_W  winning key; valid while cracked is high.

Behaviour:
- Reset: state=IDLE, next_key=KEY_FIRST, core_busy=0, core_start=0, core_key=0, busy=0, cracked=0, failed=0, found_key=0.
- Reset mid-search: the same clear applies immediately. Cores are not reset by this block; the top level resets cores with the same rst.
- States:
  - IDLE: go -> DISPATCH. Clear next_key to KEY_FIRST, clear cracked/failed/found_key.
  - DISPATCH, each cycle:
    - Pick the lowest-index core with core_busy=0 that does not have core_done this cycle.
    - If one exists and next_key has not passed KEY_LAST: pulse its core_start, register core_key=next_key, set its core_busy, next_key++.
    - Dispatch latency from go: the first start appears in the cycle after go is sampled.
  - Done handling (DISPATCH and DRAIN): core_done[i] clears core_busy[i] in the same edge.
    - If core_cracked[i] is set and no key is recorded yet, capture core_key[i] into found_key and go to DRAIN with hit=1.
    - Simultaneous cracked dones: lowest index wins.
    - A done and a re-dispatch of the same core never occur in the same cycle; the freed core is eligible the next cycle.
  - Exhaustion: after issuing KEY_LAST, set the issued_all flag and go to DRAIN; no further starts. KEY_LAST=24'hFFFFFF must not wrap, so use a KEY_W+1 bit counter.
  - DRAIN: no starts. When core_busy==0:
    - go to FOUND if hit=1, else EXHAUSTED.
    - A later cracked done in DRAIN is ignored if hit=1; otherwise it sets hit and is captured.
  - FOUND: cracked=1, found_key held. go -> IDLE-clear then DISPATCH (restart from KEY_FIRST).
  - EXHAUSTED: failed=1. go restarts the same way.
- go while busy is ignored.
- core_done on a core that is not busy is ignored; flag it with an assertion in simulation.

Optional Feature:
- KEY_PROGRESS_EN defined: adds output keys_done[KEY_W:0], counting core_done pulses.
  - Cleared on reset and on an accepted go.
  - Saturates at 2**KEY_W; increments by popcount(core_done) each cycle.
- Undefined: no port and no counter logic.

Decomposition:
- Package codebreak_pkg:
  - sched_state_t enum {IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED}.
  - KEY_W_DEF=24 and KEY_LAST_DEF=24'h3FFFFF.
- One sub-module, key_slot_pick: a parameterised lowest-index-set priority encoder returning a valid bit plus index. Used for free-core selection and for cracked-winner selection.

Test Plan:
- NUM_CORES=2, KEY_FIRST=0, KEY_LAST=7, stub cores with 5-cycle done, never cracked:
  - keys 0..7 each started exactly once;
  - failed=1 after the last done; cracked=0; busy falls the same cycle failed rises.
- NUM_CORES=4, stub cracks on key 24'h000249 (range 0..0x3FF):
  - cracked=1, found_key=24'h000249;
  - no core_start after the crack is recorded;
  - FOUND entered only when all cores are idle.
- Two cores report cracked in the same cycle (keys 5 on core 1, 4 on core 3) -> found_key=5 (lowest core index).
- Assert rst while 3 cores are busy mid-search:
  - all outputs reach reset values without a clock edge;
  - a later go restarts from KEY_FIRST.
- go pulsed during DISPATCH -> ignored: next_key sequence unbroken.
  - Then go in FOUND -> cracked clears and dispatch restarts from KEY_FIRST.
- KEY_LAST=24'hFFFFFF, KEY_FIRST=24'hFFFFFD, NUM_CORES=1 -> exactly 3 starts, no wrap to 0, then EXHAUSTED.
  - With KEY_PROGRESS_EN: keys_done=3.
